stopwatch_lap_ctrl: RTL and testbench

Parametrised stopwatch/timer controller with lap capture. Counts seconds and minutes from a programmable clock prescaler, either up (stopwatch) or down from a preset (countdown timer). On LAP it emits a one-cycle write of the current time into an external lap RAM with a bounded address pointer. It sits between the command decoder (buttons/UART) and the display driver plus the lap memory.

---
 rtl/stopwatch_lap_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - up/down seconds:minutes stopwatch with bounded lap RAM writer
// Commands arrive as one-cycle strobes; every output is a register updated on the rising edge.
module stopwatch_lap_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int MIN_WIDTH = 8,
  parameter int MIN_MAX   = 99,
  parameter int ADR_WIDTH = 10,
  parameter int LAP_DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  input  logic [1:0]               comanda,
  input  logic                     mode,
  input  logic [5:0]               preset_s,
  input  logic [MIN_WIDTH-1:0]     preset_m,
  output logic [5:0]               timp_s,
  output logic [MIN_WIDTH-1:0]     timp_m,
  output logic                     running,
  output logic                     done,
  output logic                     ovf,
  output logic                     lap_we,
  output logic [ADR_WIDTH-1:0]     lap_adr,
  output logic [6+MIN_WIDTH-1:0]   lap_data,
  output logic [ADR_WIDTH:0]       lap_cnt,
  output logic                     lap_full
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW = ADR_WIDTH + 1;
  localparam logic [PW-1:0]        TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [MIN_WIDTH-1:0] M_MAX     = MIN_WIDTH'(MIN_MAX);
  localparam logic [CW-1:0]        DEPTH     = CW'(LAP_DEPTH);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_LAP   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t               state;
  logic                 mode_r;
  logic [PW-1:0]        presc;

  logic                 tick;
  logic                 cmd_clear, cmd_start, cmd_stop, cmd_lap, lap_ok;
  logic [5:0]           up_s, dn_s, pre_s;
  logic [MIN_WIDTH-1:0] up_m, dn_m, pre_m;
  logic                 up_wrap, dn_zero;

  assign cmd_clear = cmd_valid && (comanda == CMD_CLEAR);
  assign cmd_start = cmd_valid && (comanda == CMD_START);
  assign cmd_stop  = cmd_valid && (comanda == CMD_STOP);
  assign cmd_lap   = cmd_valid && (comanda == CMD_LAP);
  assign tick      = (state == S_RUN) && (presc == TICK_LAST);
  assign lap_ok    = cmd_lap && ((state == S_RUN) || (state == S_PAUSE)) && !lap_full;

  assign pre_s = (preset_s > 6'd59) ? 6'd59 : preset_s;
  assign pre_m = (preset_m > M_MAX) ? M_MAX : preset_m;

  // Candidate next times for both directions; the FSM picks one on a tick.
  always_comb begin
    up_s    = timp_s + 6'd1;
    up_m    = timp_m;
    up_wrap = 1'b0;
    if (timp_s == 6'd59) begin
      up_s = 6'd0;
      if (timp_m == M_MAX) begin
        up_m    = '0;
        up_wrap = 1'b1;
      end else begin
        up_m = timp_m + MIN_WIDTH'(1);
      end
    end

    dn_s = timp_s - 6'd1;
    dn_m = timp_m;
    if (timp_s == 6'd0) begin
      if (timp_m != '0) begin
        dn_s = 6'd59;
        dn_m = timp_m - MIN_WIDTH'(1);
      end else begin
        dn_s = 6'd0;
      end
    end
    dn_zero = (dn_s == 6'd0) && (dn_m == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mode_r   <= 1'b0;
      presc    <= '0;
      timp_s   <= '0;
      timp_m   <= '0;
      running  <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      lap_we   <= 1'b0;
      lap_adr  <= '0;
      lap_data <= '0;
      lap_cnt  <= '0;
      lap_full <= 1'b0;
    end else begin
      lap_we <= 1'b0;
      done   <= 1'b0;

      // Lap captures the time as registered, before any tick on this same edge.
      if (lap_ok) begin
        lap_we   <= 1'b1;
        lap_adr  <= lap_cnt[ADR_WIDTH-1:0];
        lap_data <= {timp_m, timp_s};
        lap_cnt  <= lap_cnt + CW'(1);
        lap_full <= ((lap_cnt + CW'(1)) == DEPTH);
      end

      if (cmd_clear) begin
        state    <= S_IDLE;
        running  <= 1'b0;
        presc    <= '0;
        ovf      <= 1'b0;
        lap_cnt  <= '0;
        lap_adr  <= '0;
        lap_full <= 1'b0;
        mode_r   <= mode;
        timp_s   <= mode ? pre_s : 6'd0;
        timp_m   <= mode ? pre_m : '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_start) begin
              state   <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            if (cmd_stop) begin
              state   <= S_PAUSE;
              running <= 1'b0;
            end else begin
              presc <= tick ? '0 : presc + PW'(1);
              if (tick) begin
                if (mode_r) begin
                  timp_s <= dn_s;
                  timp_m <= dn_m;
                  if (dn_zero) begin
                    state   <= S_DONE;
                    running <= 1'b0;
                    done    <= 1'b1;
                  end
                end else begin
                  timp_s <= up_s;
                  timp_m <= up_m;
                  if (up_wrap) ovf <= 1'b1;
                end
              end
            end
          end
          S_PAUSE: begin
            if (cmd_start) begin
              state   <= S_RUN;
              running <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb/tb_stopwatch_lap_ctrl.sv - directed self-checking bench for stopwatch_lap_ctrl
module tb_stopwatch_lap_ctrl;

  localparam int MW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [1:0]    comanda;
  logic          mode;
  logic [5:0]    preset_s;
  logic [MW-1:0] preset_m;
  logic [5:0]    timp_s;
  logic [MW-1:0] timp_m;
  logic          running, done, ovf, lap_we, lap_full;
  logic [AW-1:0] lap_adr;
  logic [6+MW-1:0] lap_data;
  logic [AW:0]   lap_cnt;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] CLEAR = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] STOP  = 2'b10;
  localparam logic [1:0] LAP   = 2'b11;

  stopwatch_lap_ctrl #(
    .TICK_DIV(4), .MIN_WIDTH(MW), .MIN_MAX(3), .ADR_WIDTH(AW), .LAP_DEPTH(3)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .comanda(comanda), .mode(mode),
    .preset_s(preset_s), .preset_m(preset_m), .timp_s(timp_s), .timp_m(timp_m),
    .running(running), .done(done), .ovf(ovf), .lap_we(lap_we), .lap_adr(lap_adr),
    .lap_data(lap_data), .lap_cnt(lap_cnt), .lap_full(lap_full)
  );

  always #5 clk = ~clk;

  // Called on a negedge; returns on the negedge after the command edge.
  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    comanda   = c;
    @(negedge clk);
    cmd_valid = 1'b0;
    comanda   = 2'b00;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; comanda = START;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; comanda = CLEAR;
    checks++;
    if ({timp_s, timp_m, running, done, ovf, lap_we, lap_adr, lap_data, lap_cnt, lap_full} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: s=%0d m=%0d run=%b done=%b ovf=%b we=%b adr=%0d data=%0h cnt=%0d full=%b, want all 0",
               timp_s, timp_m, running, done, ovf, lap_we, lap_adr, lap_data, lap_cnt, lap_full);
    end
    wait_cyc(2);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL reset_idle_hold: running=%b want 0", running); end
  endtask

  task automatic test_count_up;
    send(START);
    wait_cyc(244);
    checks++;
    if ({timp_m, timp_s, running} !== {8'd1, 6'd1, 1'b1}) begin
      errors++; $display("FAIL up_61_ticks: m=%0d s=%0d run=%b want 1 1 1", timp_m, timp_s, running);
    end
    send(STOP);
    wait_cyc(100);
    checks++;
    if ({timp_m, timp_s, running} !== {8'd1, 6'd1, 1'b0}) begin
      errors++; $display("FAIL pause_frozen: m=%0d s=%0d run=%b want 1 1 0", timp_m, timp_s, running);
    end
    send(START);
    wait_cyc(3);
    checks++;
    if (timp_s !== 6'd1) begin errors++; $display("FAIL resume_pre_tick: s=%0d want 1", timp_s); end
    wait_cyc(1);
    checks++;
    if (timp_s !== 6'd2) begin errors++; $display("FAIL resume_tick: s=%0d want 2", timp_s); end
  endtask

  task automatic test_wrap;
    mode = 1'b0;
    send(CLEAR);
    checks++;
    if ({timp_m, timp_s, running} !== '0) begin
      errors++; $display("FAIL clear_up: m=%0d s=%0d run=%b want 0 0 0", timp_m, timp_s, running);
    end
    send(START);
    wait_cyc(956);
    checks++;
    if ({timp_m, timp_s, ovf} !== {8'd3, 6'd59, 1'b0}) begin
      errors++; $display("FAIL pre_wrap: m=%0d s=%0d ovf=%b want 3 59 0", timp_m, timp_s, ovf);
    end
    wait_cyc(4);
    checks++;
    if ({timp_m, timp_s, ovf, running} !== {8'd0, 6'd0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wrap: m=%0d s=%0d ovf=%b run=%b want 0 0 1 1", timp_m, timp_s, ovf, running);
    end
    send(CLEAR);
    checks++;
    if ({ovf, running} !== 2'b00) begin
      errors++; $display("FAIL clear_ovf: ovf=%b run=%b want 0 0", ovf, running);
    end
  endtask

  task automatic test_countdown;
    mode = 1'b1; preset_m = 8'd1; preset_s = 6'd2;
    send(CLEAR);
    checks++;
    if ({timp_m, timp_s} !== {8'd1, 6'd2}) begin
      errors++; $display("FAIL preset_load: m=%0d s=%0d want 1 2", timp_m, timp_s);
    end
    send(START);
    wait_cyc(244);
    checks++;
    if ({timp_m, timp_s, done, running} !== {8'd0, 6'd1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL down_61: m=%0d s=%0d done=%b run=%b want 0 1 0 1", timp_m, timp_s, done, running);
    end
    wait_cyc(3);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_early: done=%b want 0", done); end
    wait_cyc(1);
    checks++;
    if ({timp_m, timp_s, done, running} !== {8'd0, 6'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL done_pulse: m=%0d s=%0d done=%b run=%b want 0 0 1 0", timp_m, timp_s, done, running);
    end
    wait_cyc(1);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: done=%b want 0", done); end
    send(START);
    wait_cyc(8);
    checks++;
    if ({timp_m, timp_s, done, running} !== '0) begin
      errors++; $display("FAIL done_start_ignored: m=%0d s=%0d done=%b run=%b want 0 0 0 0", timp_m, timp_s, done, running);
    end
    preset_m = 8'd200; preset_s = 6'd63;
    send(CLEAR);
    checks++;
    if ({timp_m, timp_s} !== {8'd3, 6'd59}) begin
      errors++; $display("FAIL preset_clamp: m=%0d s=%0d want 3 59", timp_m, timp_s);
    end
    preset_m = 8'd0; preset_s = 6'd0;
    send(CLEAR);
    send(START);
    wait_cyc(3);
    checks++;
    if ({running, done} !== 2'b10) begin
      errors++; $display("FAIL zero_preset_run: run=%b done=%b want 1 0", running, done);
    end
    wait_cyc(1);
    checks++;
    if ({timp_m, timp_s, done, running} !== {8'd0, 6'd0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL zero_preset_done: m=%0d s=%0d done=%b run=%b want 0 0 1 0", timp_m, timp_s, done, running);
    end
  endtask

  task automatic test_lap;
    mode = 1'b0;
    send(CLEAR);
    send(LAP);
    checks++;
    if ({lap_we, lap_cnt} !== '0) begin
      errors++; $display("FAIL lap_idle: we=%b cnt=%0d want 0 0", lap_we, lap_cnt);
    end
    send(START);
    wait_cyc(4);
    send(LAP);
    checks++;
    if ({lap_we, lap_adr, lap_data, lap_cnt, lap_full} !== {1'b1, 2'd0, 8'd0, 6'd1, 3'd1, 1'b0}) begin
      errors++; $display("FAIL lap1: we=%b adr=%0d data=%0h cnt=%0d full=%b want 1 0 1 1 0", lap_we, lap_adr, lap_data, lap_cnt, lap_full);
    end
    wait_cyc(7);
    send(LAP);
    checks++;
    if ({lap_we, lap_adr, lap_data, lap_cnt, lap_full} !== {1'b1, 2'd1, 8'd0, 6'd3, 3'd2, 1'b0}) begin
      errors++; $display("FAIL lap2: we=%b adr=%0d data=%0h cnt=%0d full=%b want 1 1 3 2 0", lap_we, lap_adr, lap_data, lap_cnt, lap_full);
    end
    wait_cyc(7);
    send(LAP);
    checks++;
    if ({lap_we, lap_adr, lap_data, lap_cnt, lap_full} !== {1'b1, 2'd2, 8'd0, 6'd5, 3'd3, 1'b1}) begin
      errors++; $display("FAIL lap3: we=%b adr=%0d data=%0h cnt=%0d full=%b want 1 2 5 3 1", lap_we, lap_adr, lap_data, lap_cnt, lap_full);
    end
    wait_cyc(1);
    checks++;
    if ({lap_we, lap_adr} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL lap_hold: we=%b adr=%0d want 0 2", lap_we, lap_adr);
    end
    wait_cyc(6);
    send(LAP);
    checks++;
    if ({lap_we, lap_cnt, lap_full, timp_m, timp_s} !== {1'b0, 3'd3, 1'b1, 8'd0, 6'd7}) begin
      errors++; $display("FAIL lap_full_ignored: we=%b cnt=%0d full=%b m=%0d s=%0d want 0 3 1 0 7", lap_we, lap_cnt, lap_full, timp_m, timp_s);
    end
  endtask

  task automatic test_lap_on_tick;
    mode = 1'b0;
    send(CLEAR);
    checks++;
    if ({lap_cnt, lap_full, lap_adr} !== '0) begin
      errors++; $display("FAIL clear_laps: cnt=%0d full=%b adr=%0d want 0 0 0", lap_cnt, lap_full, lap_adr);
    end
    send(START);
    wait_cyc(236);
    checks++;
    if ({timp_m, timp_s} !== {8'd0, 6'd59}) begin
      errors++; $display("FAIL at_0_59: m=%0d s=%0d want 0 59", timp_m, timp_s);
    end
    wait_cyc(3);
    send(LAP);
    checks++;
    if ({lap_we, lap_adr, lap_data, timp_m, timp_s} !== {1'b1, 2'd0, 8'd0, 6'd59, 8'd1, 6'd0}) begin
      errors++; $display("FAIL lap_tick: we=%b adr=%0d data=%0h m=%0d s=%0d want 1 0 3b 1 0", lap_we, lap_adr, lap_data, timp_m, timp_s);
    end
  endtask

  task automatic test_reset_mid_run;
    mode = 1'b0;
    send(CLEAR);
    send(START);
    wait_cyc(4);
    send(LAP);
    wait_cyc(783);
    checks++;
    if ({timp_m, timp_s, lap_cnt} !== {8'd3, 6'd17, 3'd1}) begin
      errors++; $display("FAIL at_3_17: m=%0d s=%0d cnt=%0d want 3 17 1", timp_m, timp_s, lap_cnt);
    end
    rst = 1'b1; cmd_valid = 1'b1; comanda = LAP;
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0; comanda = CLEAR;
    checks++;
    if ({timp_s, timp_m, running, done, ovf, lap_we, lap_adr, lap_data, lap_cnt, lap_full} !== '0) begin
      errors++;
      $display("FAIL reset_mid_run: s=%0d m=%0d run=%b done=%b ovf=%b we=%b adr=%0d data=%0h cnt=%0d full=%b, want all 0",
               timp_s, timp_m, running, done, ovf, lap_we, lap_adr, lap_data, lap_cnt, lap_full);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; comanda = CLEAR; mode = 1'b0;
    preset_s = '0; preset_m = '0;
    wait_cyc(2);
    test_reset;
    test_count_up;
    test_wrap;
    test_countdown;
    test_lap;
    test_lap_on_tick;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
